register_file_idu: RTL and testbench

- Parametrised successor to the CPU register file.
- Holds NUM_PAIRS 8/16-bit register pairs plus SP and PC.
- Adds synchronous reset, two independent 8-bit read ports, and a flag-register mask.
- Adds an on-board increment/decrement unit (IDU) for PC++, SP--, HL+/HL- and the address bus. Sits between the decoder/sequencer and the ALU/bus interface.

---
 rtl/register_file_idu_pkg.sv | 31 +++
 rtl/register_file_idu_if.sv | 55 +++++
 rtl/register_file_idu_reg_pair.sv | 79 +++++++
 rtl/register_file_idu.sv | 116 +++++++++++
 tb/tb_register_file_idu.sv | 305 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/register_file_idu_pkg.sv
// regfile_pkg: shared constants for the register file with increment/decrement unit.
//   - Pair indices (WZ/BC/DE/HL/AF).
//   - SP/PC index helpers: SP and PC sit just after the general pairs.
//   - IDU opcodes.
//   - Default reset values for SP and PC.
// No ports. Not affected by the REGFILE_WRITE_BYPASS_EN macro.
package regfile_pkg;

  localparam int PAIR_WZ = 0;
  localparam int PAIR_BC = 1;
  localparam int PAIR_DE = 2;
  localparam int PAIR_HL = 3;
  localparam int PAIR_AF = 4;

  function automatic int sp_index(input int num_pairs);
    return num_pairs;
  endfunction

  function automatic int pc_index(input int num_pairs);
    return num_pairs + 1;
  endfunction

  localparam logic [1:0] IDU_NONE = 2'b00;
  localparam logic [1:0] IDU_INC  = 2'b01;
  localparam logic [1:0] IDU_DEC  = 2'b10;
  localparam logic [1:0] IDU_PASS = 2'b11;

  localparam logic [15:0] DEFAULT_RESET_SP = 16'hFFFE;
  localparam logic [15:0] DEFAULT_RESET_PC = 16'h0000;

endpackage

// File: rtl/register_file_idu_if.sv
// register_file_idu_if: bus bundle between the decoder/sequencer and the register file.
//
// Signals, as seen from the register file:
//   Inputs:
//     i_Enable               clock enable
//     i_ReadA8/i_ReadB8      8-bit read selects
//     i_Write8, i_Bus8       8-bit write select and data
//     i_Read16               16-bit read select
//     i_Write16, i_Bus16     16-bit write select and data
//     i_Idu_Sel, i_Idu_Op    IDU target and operation
//   Outputs:
//     o_BusA8/o_BusB8        8-bit read data
//     o_Bus16                16-bit read data
//     o_Idu_Addr             address bus value
//     o_HL, o_SP             always-visible HL and SP
//
// Modports:
//   master  the sequencer side
//   slave   the register file
// Not affected by the REGFILE_WRITE_BYPASS_EN macro.
interface register_file_idu_if
  import regfile_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int NUM_PAIRS = 5
);
  logic                     i_Enable;
  logic [2*NUM_PAIRS-1:0]   i_ReadA8;
  logic [2*NUM_PAIRS-1:0]   i_ReadB8;
  logic [2*NUM_PAIRS-1:0]   i_Write8;
  logic [DATA_W-1:0]        i_Bus8;
  logic [DATA_W-1:0]        o_BusA8;
  logic [DATA_W-1:0]        o_BusB8;
  logic [NUM_PAIRS+1:0]     i_Read16;
  logic [NUM_PAIRS+1:0]     i_Write16;
  logic [2*DATA_W-1:0]      i_Bus16;
  logic [2*DATA_W-1:0]      o_Bus16;
  logic [NUM_PAIRS+1:0]     i_Idu_Sel;
  logic [1:0]               i_Idu_Op;
  logic [2*DATA_W-1:0]      o_Idu_Addr;
  logic [2*DATA_W-1:0]      o_HL;
  logic [2*DATA_W-1:0]      o_SP;

  modport master (
    output i_Enable, i_ReadA8, i_ReadB8, i_Write8, i_Bus8,
           i_Read16, i_Write16, i_Bus16, i_Idu_Sel, i_Idu_Op,
    input  o_BusA8, o_BusB8, o_Bus16, o_Idu_Addr, o_HL, o_SP
  );

  modport slave (
    input  i_Enable, i_ReadA8, i_ReadB8, i_Write8, i_Bus8,
           i_Read16, i_Write16, i_Bus16, i_Idu_Sel, i_Idu_Op,
    output o_BusA8, o_BusB8, o_Bus16, o_Idu_Addr, o_HL, o_SP
  );
endinterface

// File: rtl/register_file_idu_reg_pair.sv
// reg_pair: one 2*DATA_W register with a synchronous reset value.
//
// Update priority, applied when enabled:
//   1. full write
//   2. half writes (either or both halves)
//   3. IDU result
// With MASK_FLAGS set, bits [3:0] are forced to zero before storage.
//
// Ports:
//   clk_i, rst_i, en_i            clock, sync active-high reset, enable
//   wr16_i, data16_i              full-pair write
//   wr_hi_i, wr_lo_i, data8_i     half writes
//   idu_en_i, idu_val_i           IDU update and its result
//   q_o                           stored value
//   rd_o                          value presented to the read ports
//
// Macro REGFILE_WRITE_BYPASS_EN:
//   Defined: rd_o forwards the write value in the same cycle.
//   Undefined: rd_o equals q_o.
module reg_pair
  import regfile_pkg::*;
#(
  parameter int                    DATA_W     = 8,
  parameter logic [2*DATA_W-1:0]   RESET_VAL  = '0,
  parameter bit                    MASK_FLAGS = 1'b0
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 en_i,
  input  logic                 wr16_i,
  input  logic                 wr_hi_i,
  input  logic                 wr_lo_i,
  input  logic [2*DATA_W-1:0]  data16_i,
  input  logic [DATA_W-1:0]    data8_i,
  input  logic                 idu_en_i,
  input  logic [2*DATA_W-1:0]  idu_val_i,
  output logic [2*DATA_W-1:0]  q_o,
  output logic [2*DATA_W-1:0]  rd_o
);
  localparam int PW = 2 * DATA_W;
  localparam logic [PW-1:0] KEEP_MASK =
    MASK_FLAGS ? {{(PW-4){1'b1}}, 4'h0} : {PW{1'b1}};

  logic [PW-1:0] pair_q;
  logic [PW-1:0] pair_d;
  logic [PW-1:0] wr_data;
  logic          wr_act;

  // Write-only value: independent of the IDU so it can also feed the bypass path.
  always_comb begin
    wr_data = pair_q;
    if (wr16_i) begin
      wr_data = data16_i;
    end else begin
      if (wr_hi_i) wr_data[PW-1:DATA_W] = data8_i;
      if (wr_lo_i) wr_data[DATA_W-1:0]  = data8_i;
    end
    wr_data = wr_data & KEEP_MASK;
  end

  assign wr_act = wr16_i | wr_hi_i | wr_lo_i;
  assign pair_d = wr_act   ? wr_data :
                  idu_en_i ? (idu_val_i & KEEP_MASK) : pair_q;

  always_ff @(posedge clk_i) begin
    if (rst_i)     pair_q <= RESET_VAL;
    else if (en_i) pair_q <= pair_d;
  end

  assign q_o = pair_q;

`ifdef REGFILE_WRITE_BYPASS_EN
  // Nothing lands during reset, so nothing is forwarded then either.
  assign rd_o = (en_i && !rst_i && wr_act) ? wr_data : pair_q;
`else
  assign rd_o = pair_q;
`endif

endmodule

// File: rtl/register_file_idu.sv
// register_file_idu: register file with an increment/decrement unit (IDU).
//
// Contents:
//   - NUM_PAIRS general pairs, plus SP and PC.
//   - Two 8-bit read ports and one 16-bit read port.
//   - 8-bit and 16-bit write ports.
//   - IDU for PC++, SP-- and HL+/HL-, with post-increment address output.
//   - FLAG_PAIR low nibble hard-wired to zero.
//
// Ports:
//   i_Clk     clock
//   i_Reset   synchronous active-high reset
//   bus       register_file_idu_if.slave bundle
//
// Macro REGFILE_WRITE_BYPASS_EN:
//   Defined: read ports forward same-cycle write data.
//   o_Idu_Addr, o_HL and o_SP always show stored values.
module register_file_idu
  import regfile_pkg::*;
#(
  parameter int                  DATA_W    = 8,
  parameter int                  NUM_PAIRS = 5,
  parameter int                  FLAG_PAIR = 4,
  parameter logic [2*DATA_W-1:0] RESET_SP  = DEFAULT_RESET_SP,
  parameter logic [2*DATA_W-1:0] RESET_PC  = DEFAULT_RESET_PC
) (
  input logic                i_Clk,
  input logic                i_Reset,
  register_file_idu_if.slave bus
);
  localparam int NR     = NUM_PAIRS + 2;
  localparam int PW     = 2 * DATA_W;
  localparam int SP_IDX = sp_index(NUM_PAIRS);
  localparam int PC_IDX = pc_index(NUM_PAIRS);

  logic [PW-1:0] pair_q  [NR];
  logic [PW-1:0] rd_val  [NR];
  logic [PW-1:0] idu_val [NR];
  logic          idu_step;

  logic [DATA_W-1:0] bus_a;
  logic [DATA_W-1:0] bus_b;
  logic [PW-1:0]     bus16;
  logic [PW-1:0]     idu_addr;

  // PASS only drives the address bus; NONE does nothing.
  assign idu_step = (bus.i_Idu_Op == IDU_INC) || (bus.i_Idu_Op == IDU_DEC);

  for (genvar g = 0; g < NR; g++) begin : g_pair
    logic wr_hi;
    logic wr_lo;

    // SP and PC have no 8-bit access.
    if (g < NUM_PAIRS) begin : g_gp
      assign wr_hi = bus.i_Write8[2*g];
      assign wr_lo = bus.i_Write8[2*g+1];
    end else begin : g_spc
      assign wr_hi = 1'b0;
      assign wr_lo = 1'b0;
    end

    assign idu_val[g] = (bus.i_Idu_Op == IDU_DEC) ? pair_q[g] - PW'(1)
                                                  : pair_q[g] + PW'(1);

    reg_pair #(
      .DATA_W     (DATA_W),
      .RESET_VAL  ((g == SP_IDX) ? RESET_SP : (g == PC_IDX) ? RESET_PC : {PW{1'b0}}),
      .MASK_FLAGS (g == FLAG_PAIR)
    ) u_pair (
      .clk_i     (i_Clk),
      .rst_i     (i_Reset),
      .en_i      (bus.i_Enable),
      .wr16_i    (bus.i_Write16[g]),
      .wr_hi_i   (wr_hi),
      .wr_lo_i   (wr_lo),
      .data16_i  (bus.i_Bus16),
      .data8_i   (bus.i_Bus8),
      .idu_en_i  (bus.i_Idu_Sel[g] && idu_step),
      .idu_val_i (idu_val[g]),
      .q_o       (pair_q[g]),
      .rd_o      (rd_val[g])
    );
  end

  // AND-OR read muxes: zero-hot reads 0, multi-hot ORs (flagged below).
  // 8-bit register r is the high half of pair r/2 when r is even.
  always_comb begin
    bus_a    = '0;
    bus_b    = '0;
    bus16    = '0;
    idu_addr = '0;
    for (int r = 0; r < 2*NUM_PAIRS; r++) begin
      if (bus.i_ReadA8[r])
        bus_a |= (r % 2 == 0) ? rd_val[r/2][PW-1:DATA_W] : rd_val[r/2][DATA_W-1:0];
      if (bus.i_ReadB8[r])
        bus_b |= (r % 2 == 0) ? rd_val[r/2][PW-1:DATA_W] : rd_val[r/2][DATA_W-1:0];
    end
    for (int p = 0; p < NR; p++) begin
      if (bus.i_Read16[p])  bus16    |= rd_val[p];
      if (bus.i_Idu_Sel[p]) idu_addr |= pair_q[p];
    end
  end

  assign bus.o_BusA8    = bus_a;
  assign bus.o_BusB8    = bus_b;
  assign bus.o_Bus16    = bus16;
  assign bus.o_Idu_Addr = idu_addr;
  assign bus.o_HL       = pair_q[PAIR_HL];
  assign bus.o_SP       = pair_q[SP_IDX];

  a_reada_onehot: assert property (@(posedge i_Clk) disable iff (i_Reset) $onehot0(bus.i_ReadA8));
  a_readb_onehot: assert property (@(posedge i_Clk) disable iff (i_Reset) $onehot0(bus.i_ReadB8));
  a_r16_onehot:   assert property (@(posedge i_Clk) disable iff (i_Reset) $onehot0(bus.i_Read16));
  a_idu_onehot:   assert property (@(posedge i_Clk) disable iff (i_Reset) $onehot0(bus.i_Idu_Sel));

endmodule

// File: tb/tb_register_file_idu.sv
module tb_register_file_idu;
  localparam int NP = 5;
  localparam int NR = NP + 2;

  bit   clk;
  logic rst;
  int   n_checks = 0;
  int   n_err    = 0;

  always #5 clk = ~clk;

  register_file_idu_if #(.DATA_W(8), .NUM_PAIRS(NP)) bus ();

  register_file_idu #(
    .DATA_W    (8),
    .NUM_PAIRS (NP),
    .FLAG_PAIR (4),
    .RESET_SP  (16'hFFFE),
    .RESET_PC  (16'h0000)
  ) dut (
    .i_Clk   (clk),
    .i_Reset (rst),
    .bus     (bus)
  );

  // Reference model: index 0..4 pairs, 5 = SP, 6 = PC.
  logic [15:0] m [NR];
  bit          model_valid = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit w8_hit(input int r);
    if (r >= 2*NP) return 1'b0;
    return bus.i_Write8[r];
  endfunction

  function automatic bit write_hit(input int p);
    return bus.i_Write16[p] || w8_hit(2*p) || w8_hit(2*p+1);
  endfunction

  // Value a register takes from the write ports alone, with priority and mask.
  function automatic logic [15:0] write_val(input int p);
    logic [15:0] v;
    if (bus.i_Write16[p]) v = bus.i_Bus16;
    else begin
      v = m[p];
      if (w8_hit(2*p))   v = {bus.i_Bus8, v[7:0]};
      if (w8_hit(2*p+1)) v = {v[15:8], bus.i_Bus8};
    end
    if (p == 4) v = v & 16'hFFF0;
    return v;
  endfunction

  function automatic logic [15:0] eff(input int p);
`ifdef REGFILE_WRITE_BYPASS_EN
    if (bus.i_Enable && !rst && write_hit(p)) return write_val(p);
`endif
    return m[p];
  endfunction

  function automatic logic [7:0] reg8(input int r);
    logic [15:0] v;
    v = eff(r / 2);
    return (r % 2 == 0) ? v[15:8] : v[7:0];
  endfunction

  always @(posedge clk) begin
    logic [15:0] nm [NR];
    if (rst) begin
      for (int p = 0; p < NR; p++) m[p] = 16'h0000;
      m[5] = 16'hFFFE;
      m[6] = 16'h0000;
      model_valid = 1;
    end else if (model_valid && bus.i_Enable) begin
      for (int p = 0; p < NR; p++) begin
        nm[p] = m[p];
        if (write_hit(p)) nm[p] = write_val(p);
        else if (bus.i_Idu_Sel[p] && bus.i_Idu_Op == 2'b01) nm[p] = m[p] + 16'd1;
        else if (bus.i_Idu_Sel[p] && bus.i_Idu_Op == 2'b10) nm[p] = m[p] - 16'd1;
        if (p == 4) nm[p] = nm[p] & 16'hFFF0;
      end
      for (int p = 0; p < NR; p++) m[p] = nm[p];
    end
  end

  always @(negedge clk) begin
    logic [7:0]  ea, eb;
    logic [15:0] e16, eaddr;
    if (model_valid) begin
      ea = 0; eb = 0; e16 = 0; eaddr = 0;
      for (int r = 0; r < 2*NP; r++) begin
        if (bus.i_ReadA8[r]) ea = ea | reg8(r);
        if (bus.i_ReadB8[r]) eb = eb | reg8(r);
      end
      for (int p = 0; p < NR; p++) begin
        if (bus.i_Read16[p])  e16   = e16 | eff(p);
        if (bus.i_Idu_Sel[p]) eaddr = eaddr | m[p];
      end
      check("busA8",    {8'h00, bus.o_BusA8}, {8'h00, ea});
      check("busB8",    {8'h00, bus.o_BusB8}, {8'h00, eb});
      check("bus16",    bus.o_Bus16,    e16);
      check("idu_addr", bus.o_Idu_Addr, eaddr);
      check("hl",       bus.o_HL,       m[3]);
      check("sp",       bus.o_SP,       m[5]);
    end
  end

  task automatic clear();
    bus.i_ReadA8  = '0;
    bus.i_ReadB8  = '0;
    bus.i_Write8  = '0;
    bus.i_Bus8    = '0;
    bus.i_Read16  = '0;
    bus.i_Write16 = '0;
    bus.i_Bus16   = '0;
    bus.i_Idu_Sel = '0;
    bus.i_Idu_Op  = 2'b00;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] oh0(input int w);
    if ($urandom_range(0, 3) == 0) return 32'd0;
    return 32'd1 << $urandom_range(0, w - 1);
  endfunction

  initial begin
    logic [31:0] s;
    clear();
    rst = 1;
    bus.i_Enable = 0;
    step();
    rst = 0;
    bus.i_Read16 = 7'(1 << 6);
    @(negedge clk);
    check("rst_sp", bus.o_SP, 16'hFFFE);
    check("rst_pc", bus.o_Bus16, 16'h0000);
    check("rst_hl", bus.o_HL, 16'h0000);
    step();

    // IDU post-increment on HL.
    clear();
    bus.i_Enable = 1;
    bus.i_Write16 = 7'(1 << 3); bus.i_Bus16 = 16'hC0FF;
    step();
    clear();
    bus.i_Idu_Sel = 7'(1 << 3); bus.i_Idu_Op = 2'b01;
    @(negedge clk);
    check("idu_hl_addr", bus.o_Idu_Addr, 16'hC0FF);
    step();
    clear();
    @(negedge clk);
    check("idu_hl_inc", bus.o_HL, 16'hC100);

    // IDU decrement wrap on SP.
    step();
    bus.i_Write16 = 7'(1 << 5); bus.i_Bus16 = 16'h0000;
    step();
    clear();
    bus.i_Idu_Sel = 7'(1 << 5); bus.i_Idu_Op = 2'b10;
    @(negedge clk);
    check("idu_sp_addr", bus.o_Idu_Addr, 16'h0000);
    step();
    clear();
    @(negedge clk);
    check("idu_sp_dec", bus.o_SP, 16'hFFFF);

    // Priority: Write16 beats Write8 and IDU on HL; Write8 on C still lands.
    step();
    bus.i_Write16 = 7'(1 << 3); bus.i_Bus16 = 16'h1234;
    bus.i_Write8  = 10'((1 << 7) | (1 << 3)); bus.i_Bus8 = 8'h55;
    bus.i_Idu_Sel = 7'(1 << 3); bus.i_Idu_Op = 2'b01;
    step();
    clear();
    bus.i_Read16 = 7'(1 << 3);
    bus.i_ReadA8 = 10'(1 << 3);
    @(negedge clk);
    check("prio_hl", bus.o_Bus16, 16'h1234);
    check("prio_c", {8'h00, bus.o_BusA8}, 16'h0055);
    step();
    clear();
    bus.i_Read16 = 7'(1 << 1);
    @(negedge clk);
    check("prio_bc", bus.o_Bus16, 16'h0055);

    // Flag mask.
    step();
    clear();
    bus.i_Write16 = 7'(1 << 4); bus.i_Bus16 = 16'h12FF;
    step();
    clear();
    bus.i_Read16 = 7'(1 << 4);
    @(negedge clk);
    check("flag_w16", bus.o_Bus16, 16'h12F0);
    step();
    clear();
    bus.i_Write8 = 10'(1 << 9); bus.i_Bus8 = 8'h0F;
    step();
    clear();
    bus.i_ReadA8 = 10'(1 << 9);
    @(negedge clk);
    check("flag_w8", {8'h00, bus.o_BusA8}, 16'h0000);

    // Dual read and enable gating.
    step();
    clear();
    bus.i_Write8 = 10'(1 << 2); bus.i_Bus8 = 8'h3C;
    step();
    clear();
    bus.i_Write8 = 10'(1 << 5); bus.i_Bus8 = 8'hC3;
    step();
    clear();
    bus.i_ReadA8 = 10'(1 << 2);
    bus.i_ReadB8 = 10'(1 << 5);
    @(negedge clk);
    check("dual_a_b", {8'h00, bus.o_BusA8}, 16'h003C);
    check("dual_b_e", {8'h00, bus.o_BusB8}, 16'h00C3);
    step();
    clear();
    bus.i_Enable = 0;
    bus.i_Write8 = 10'(1 << 2); bus.i_Bus8 = 8'h00;
    step();
    clear();
    bus.i_Enable = 1;
    bus.i_ReadA8 = 10'(1 << 2);
    @(negedge clk);
    check("en_hold_b", {8'h00, bus.o_BusA8}, 16'h003C);

    // Same-cycle read of a register being written.
    step();
    clear();
    bus.i_Write8 = 10'(1 << 4); bus.i_Bus8 = 8'h11;
    step();
    clear();
    bus.i_Write8 = 10'(1 << 4); bus.i_Bus8 = 8'h77;
    bus.i_ReadA8 = 10'(1 << 4);
    @(negedge clk);
`ifdef REGFILE_WRITE_BYPASS_EN
    check("bypass_d", {8'h00, bus.o_BusA8}, 16'h0077);
`else
    check("bypass_d", {8'h00, bus.o_BusA8}, 16'h0011);
`endif
    step();
    clear();
    bus.i_ReadA8 = 10'(1 << 4);
    @(negedge clk);
    check("d_after", {8'h00, bus.o_BusA8}, 16'h0077);

    // Reset with enable high discards the pending write and IDU op.
    step();
    clear();
    rst = 1;
    bus.i_Write16 = 7'(1 << 3); bus.i_Bus16 = 16'hABCD;
    bus.i_Idu_Sel = 7'(1 << 5); bus.i_Idu_Op = 2'b01;
    step();
    rst = 0;
    clear();
    @(negedge clk);
    check("rst2_hl", bus.o_HL, 16'h0000);
    check("rst2_sp", bus.o_SP, 16'hFFFE);

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      step();
      rst = ($urandom_range(0, 59) == 0);
      bus.i_Enable = ($urandom_range(0, 7) != 0);
      bus.i_ReadA8 = 10'(oh0(2*NP));
      bus.i_ReadB8 = 10'(oh0(2*NP));
      bus.i_Read16 = 7'(oh0(NR));
      case ($urandom_range(0, 3))
        0:       bus.i_Write8 = '0;
        1:       bus.i_Write8 = 10'($urandom);
        default: bus.i_Write8 = 10'(oh0(2*NP));
      endcase
      case ($urandom_range(0, 3))
        0:       bus.i_Write16 = 7'($urandom);
        1:       bus.i_Write16 = '0;
        default: bus.i_Write16 = 7'(oh0(NR));
      endcase
      s = oh0(NR);
      if (s == 32'd16) s = 32'd0;
      bus.i_Idu_Sel = 7'(s);
      bus.i_Idu_Op  = 2'($urandom);
      bus.i_Bus8    = 8'($urandom);
      bus.i_Bus16   = 16'($urandom);
    end
    step();
    clear();
    rst = 0;
    step();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
